// File: rtl/serial_subtractor4bit.sv
// serial_subtractor4bit: bit-serial two's-complement subtractor.
// Computes a - b as a + ~b + 1, one bit per clock, LSB first, behind a
// start/done handshake. Flags follow the combinational adder convention:
// carryout = 1 means no borrow, overflow = carry-in(MSB) ^ carry-out(MSB).
// Optional feature macro: SERIAL_SUB_SATURATE_EN clamps diff on signed
// overflow (flags still report the unsaturated result).
module serial_subtractor4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic             sum_s;
  logic             cnext_s;
  logic             ovf_s;
  logic [WIDTH-1:0] wrap_s;
  logic [WIDTH-1:0] final_s;

  // Single-bit full-adder slice and the final-result formatting for the MSB step.
  always_comb begin
    sum_s   = a_q[0] ^ b_q[0] ^ c_q;
    cnext_s = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    // On the MSB step c_q is the carry into the MSB and cnext_s the carry out.
    ovf_s   = c_q ^ cnext_s;
    wrap_s  = {sum_s, res_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_SATURATE_EN
    // On the MSB step a_q[0] holds the original sign bit of the minuend.
    if (ovf_s) begin
      final_s = a_q[0] ? SAT_MIN : SAT_MAX;
    end else begin
      final_s = wrap_s;
    end
`else
    final_s = wrap_s;
`endif
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer and datapath registers.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    diff_d     = diff_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = ~b;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = wrap_s;
        c_d   = cnext_s;
        if (cnt_q == LAST_BIT) begin
          cnt_d      = '0;
          diff_d     = final_s;
          carryout_d = cnext_s;
          overflow_d = ovf_s;
          state_d    = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      diff_q     <= diff_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor4bit.sv
// Directed self-checking bench for serial_subtractor4bit (WIDTH = 4).
module tb_serial_subtractor4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       carryout;
  logic       overflow;

  int n_tests;
  int n_fail;
  logic [3:0] prev_diff;

  serial_subtractor4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One operation: start driven before the accepting edge, then done exactly
  // four edges later. With poke set, a second start is pulsed mid-SHIFT.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] ed, input logic eco, input logic eov,
                        input bit poke);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("hold_diff", 32'(diff), 32'(prev_diff));
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_done", 32'(done), 32'd0);
      if (poke && i == 1) begin
        @(negedge clk);
        start = 1'b1;
        a     = 4'b0001;
        b     = 4'b0111;
      end else if (poke && i == 2) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("carryout", 32'(carryout), 32'(eco));
    check("overflow", 32'(overflow), 32'(eov));
    prev_diff = ed;
  endtask

  // One idle cycle after DONE: done must have dropped and results held.
  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_diff", 32'(diff), 32'(prev_diff));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    prev_diff = 4'b0000;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = 4'b0000;
    b         = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_carryout", 32'(carryout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 3 = 2
    run_op(4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    // 2 - 7 = -5
    run_op(4'b0010, 4'b0111, 4'b1011, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    // 7 - (-8): positive overflow
`ifdef SERIAL_SUB_SATURATE_EN
    run_op(4'b0111, 4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0);
`else
    run_op(4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b1, 1'b0);
`endif
    idle_cycle();
    // -8 - 1: negative overflow
`ifdef SERIAL_SUB_SATURATE_EN
    run_op(4'b1000, 4'b0001, 4'b1000, 1'b1, 1'b1, 1'b0);
`else
    run_op(4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0);
`endif
    idle_cycle();
    // 6 - 1 = 5 with an ignored start during SHIFT
    run_op(4'b0110, 4'b0001, 4'b0101, 1'b1, 1'b0, 1'b1);
    // back-to-back: start in the DONE cycle, 0 - 0
    run_op(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    // -3 - (-3) = 0: 1101 + 0010 + 1 carries out, no overflow
    run_op(4'b1101, 4'b1101, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle_cycle();

    // Reset two cycles into SHIFT of a 5 - 3 operation.
    run_op(4'b0111, 4'b0001, 4'b0110, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b0101;
    b     = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_carryout", 32'(carryout), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_no_busy", 32'(busy), 32'd0);
    end
    run_op(4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
